memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have ports: CLK in 1 clock; nRST in 1 reset, asynchronous, active-low.
REQ-002 SHALL have iREN in 1: icache read request, held until iwait low.
REQ-003 SHALL have iaddr in 32: icache word address.
REQ-004 SHALL have iwait out 1: high = icache request not complete.
REQ-005 SHALL have iload out 32: instruction word, valid when iwait low.
REQ-006 SHALL have dREN in 1 and dWEN in 1: dcache read/write requests, held until dwait low.
REQ-007 SHALL have daddr in 32 and dstore in 32: dcache address and write data.
REQ-008 SHALL have dwait out 1 and dload out 32: dcache completion and read data.
REQ-009 SHALL have ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32: RAM command.
REQ-010 SHALL have ramload in 32 and ramstate in 2 (ramstate_t: FREE, BUSY, ACCESS, ERROR).

Function
REQ-011 SHALL implement states IDLE, IFETCH, DREAD, DWRITE.
REQ-012 IDLE: SHALL go to DWRITE if dWEN, else DREAD if dREN, else IFETCH if iREN, else stay (fixed priority, data over instruction).
REQ-013 dWEN and dREN both high SHALL be treated as write.
REQ-014 In IFETCH: ramREN=1, ramaddr=iaddr; DREAD: ramREN=1, ramaddr=daddr; DWRITE: ramWEN=1, ramaddr=daddr, ramstore=dstore; all ram outputs 0 in IDLE.
REQ-015 ramREN and ramWEN SHALL never be high simultaneously.
REQ-016 iwait and dwait SHALL default to 1; the port owning the active state SHALL see wait=0 only in a cycle where ramstate==ACCESS.
REQ-017 In that ACCESS cycle iload (IFETCH) or dload (DREAD) SHALL equal ramload combinationally; state SHALL return to IDLE next cycle.
REQ-018 Minimum transaction latency SHALL be 2 cycles: request seen in IDLE at cycle N, earliest wait low at cycle N+1.
REQ-019 ramstate BUSY, FREE or ERROR in an active state SHALL hold state and keep wait high.
REQ-020 Requester dropping its request mid-transaction SHALL return FSM to IDLE next cycle, wait stays high, ram enables drop with state.
REQ-021 iload/dload SHALL be 0 when not in their completing cycle.
REQ-022 Back-to-back: after completion, IDLE SHALL re-arbitrate one cycle later; no request is lost while held.

Reset
REQ-023 nRST low SHALL force IDLE immediately; ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
REQ-024 Reset mid-transaction SHALL abandon it; no completion signalled for it after release.

Configuration
REQ-025 MEMARB_RR_EN defined: IDLE arbitration SHALL be round-robin between icache and dcache (last-served port loses a tie; initial after reset favours dcache).
REQ-026 MEMARB_RR_EN undefined: fixed priority per REQ-012; no last-served register synthesised.

Structure
REQ-027 ramstate_t and word_t SHALL come from cpu_types_pkg; new enum memarb_state_t SHALL be added to cpu_types_pkg.
REQ-028 Grant selection SHALL live in sub-module mem_arb_select (inputs iREN, dREN, dWEN, last-served; output grant); FSM and muxing in memory_arbiter.

Verification
REQ-029 iREN=1, iaddr=0x0000_0040, ramstate BUSY 2 cycles then ACCESS, ramload=0x2002_0001 -> ramREN=1, ramaddr=0x40; iwait low exactly one cycle with iload=0x2002_0001.
REQ-030 dWEN=1, daddr=0x100, dstore=0xDEAD_BEEF, ramstate ACCESS immediately -> ramWEN=1, ramstore=0xDEADBEEF, dwait low cycle N+1, iwait stays 1.
REQ-031 iREN and dREN asserted same cycle, fixed priority -> DREAD served first, then IFETCH; with MEMARB_RR_EN and second conflict -> icache served first.
REQ-032 nRST pulsed while in DREAD with ramstate BUSY -> next cycle all ram outputs 0, dwait=1, state IDLE, no spurious dwait low after ACCESS arrives.
REQ-033 dREN dropped mid-DREAD -> IDLE next cycle, ramREN=0, dwait never low.
REQ-034 ramstate ERROR for 5 cycles then ACCESS during IFETCH -> iwait high throughout ERROR, low only on ACCESS cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: memory word, RAM handshake state and memory arbiter FSM states.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } memarb_state_t;

  // A data request carrying a write strobe is a write, even if the read strobe is also up.
  function automatic memarb_state_t data_grant(input logic dwen);
    return dwen ? DWRITE : DREAD;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Grant selection for the memory arbiter's IDLE state.
// MEMARB_RR_EN: round-robin between icache and dcache; otherwise fixed data-over-instruction priority.
module mem_arb_select
  import cpu_types_pkg::*;
(
  input  logic          i_iren,
  input  logic          i_dren,
  input  logic          i_dwen,
  input  logic          i_last_dcache,
  output memarb_state_t o_grant
);

  logic w_dreq;
  assign w_dreq = i_dren | i_dwen;

`ifdef MEMARB_RR_EN
  // On a tie the port served most recently yields.
  always_comb begin
    o_grant = IDLE;
    if (w_dreq && i_iren) begin
      o_grant = i_last_dcache ? IFETCH : data_grant(i_dwen);
    end else if (w_dreq) begin
      o_grant = data_grant(i_dwen);
    end else if (i_iren) begin
      o_grant = IFETCH;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = i_last_dcache;

  always_comb begin
    o_grant = IDLE;
    if (w_dreq) begin
      o_grant = data_grant(i_dwen);
    end else if (i_iren) begin
      o_grant = IFETCH;
    end
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates icache and dcache requests onto a single RAM port.
// MEMARB_RR_EN selects round-robin arbitration in IDLE (default build: fixed priority).
module memory_arbiter
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  memarb_state_t r_state;
  memarb_state_t w_next_state;
  memarb_state_t w_grant;
  logic          w_last_dcache;
  logic          w_access;

  assign w_access = (ramstate == ACCESS);

  mem_arb_select u_select (
    .i_iren        (iREN),
    .i_dren        (dREN),
    .i_dwen        (dWEN),
    .i_last_dcache (w_last_dcache),
    .o_grant       (w_grant)
  );

`ifdef MEMARB_RR_EN
  logic r_last_dcache;

  // Cleared by reset so the first tie goes to the dcache.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_last_dcache <= 1'b0;
    end else if (r_state == IDLE && w_grant != IDLE) begin
      r_last_dcache <= (w_grant != IFETCH);
    end
  end

  assign w_last_dcache = r_last_dcache;
`else
  assign w_last_dcache = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Waits are gated by the live request so a dropped request never sees a completion.
  always_comb begin
    w_next_state = r_state;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    case (r_state)
      IDLE: begin
        w_next_state = w_grant;
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          w_next_state = IDLE;
        end else if (w_access) begin
          iwait        = 1'b0;
          iload        = ramload;
          w_next_state = IDLE;
        end
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr;
        if (!dREN) begin
          w_next_state = IDLE;
        end else if (w_access) begin
          dwait        = 1'b0;
          dload        = ramload;
          w_next_state = IDLE;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!dWEN) begin
          w_next_state = IDLE;
        end else if (w_access) begin
          dwait        = 1'b0;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic      CLK = 1'b0;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  memory_arbiter dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  task automatic idle_inputs();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    ramstate = FREE;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0; iREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; dstore = 32'h55;
    ramstate = ACCESS; ramload = 32'h1234_5678;
    tick(); #1;
    n_cmp++;
    if ({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_outputs: got ren=%b wen=%b addr=%h store=%h iw=%b dw=%b il=%h dl=%h, want all zero with waits 1",
               ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload);
    end
    @(posedge CLK); #1;
    n_cmp++;
    if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin
      n_bad++;
      $display("FAIL reset_held_edge: got ren/wen/iw/dw=%b want 0011", {ramREN, ramWEN, iwait, dwait});
    end
  endtask

  task automatic test_ifetch_busy();
    int lows = 0;
    reset_dut();
    iREN = 1'b1; iaddr = 32'h0000_0040; ramstate = BUSY; ramload = 32'h2002_0001;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) ramstate = ACCESS;
      if (c == 4) begin iREN = 1'b0; ramstate = FREE; end
      #1;
      if (c == 1) begin
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr} !== {1'b1, 1'b0, 32'h40}) begin
          n_bad++;
          $display("FAIL ifetch_cmd: got ren=%b wen=%b addr=%h want 1 0 00000040", ramREN, ramWEN, ramaddr);
        end
      end
      if (iwait === 1'b0) lows++;
      n_cmp++;
      if ({iwait, iload} !== {(c != 3), (c == 3) ? 32'h2002_0001 : 32'h0}) begin
        n_bad++;
        $display("FAIL ifetch_cycle%0d: got iwait=%b iload=%h want iwait=%b iload=%h",
                 c, iwait, iload, (c != 3), (c == 3) ? 32'h2002_0001 : 32'h0);
      end
      tick();
    end
    n_cmp++;
    if (lows !== 1) begin
      n_bad++;
      $display("FAIL ifetch_low_count: got %0d want 1", lows);
    end
  endtask

  task automatic test_dwrite();
    reset_dut();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; ramstate = ACCESS;
    #1;
    n_cmp++;
    if ({dwait, ramWEN, ramREN} !== 3'b100) begin
      n_bad++;
      $display("FAIL dwrite_idle: got dwait/wen/ren=%b want 100", {dwait, ramWEN, ramREN});
    end
    tick(); #1;
    n_cmp++;
    if ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait} !== {1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL dwrite_cmd: got wen=%b ren=%b addr=%h store=%h dwait=%b iwait=%b want 1 0 00000100 deadbeef 0 1",
               ramWEN, ramREN, ramaddr, ramstore, dwait, iwait);
    end
    tick();
    dWEN = 1'b0;
    #1;
    n_cmp++;
    if ({ramWEN, dwait} !== 2'b01) begin
      n_bad++;
      $display("FAIL dwrite_after: got wen/dwait=%b want 01", {ramWEN, dwait});
    end
  endtask

  task automatic test_conflict();
    reset_dut();
    iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200;
    ramload = 32'h0000_1111; ramstate = ACCESS;
    tick(); #1;
    n_cmp++;
    if ({ramREN, ramaddr, dwait, iwait, dload} !== {1'b1, 32'h200, 1'b0, 1'b1, 32'h1111}) begin
      n_bad++;
      $display("FAIL conflict_first: got ren=%b addr=%h dwait=%b iwait=%b dload=%h want DREAD of 00000200 completing",
               ramREN, ramaddr, dwait, iwait, dload);
    end
    tick();
    daddr = 32'h204;
    #1;
    n_cmp++;
    if ({ramREN, iwait, dwait} !== 3'b011) begin
      n_bad++;
      $display("FAIL conflict_gap: got ren/iw/dw=%b want 011", {ramREN, iwait, dwait});
    end
    tick(); #1;
    n_cmp++;
    if ({ramaddr, iwait, dwait} !== {RR ? 32'h44 : 32'h204, RR ? 1'b0 : 1'b1, RR ? 1'b1 : 1'b0}) begin
      n_bad++;
      $display("FAIL conflict_second: got addr=%h iwait=%b dwait=%b want addr=%h iwait=%b dwait=%b",
               ramaddr, iwait, dwait, RR ? 32'h44 : 32'h204, !RR, RR);
    end
    tick();
    iREN = !RR; dREN = RR;
    tick(); #1;
    n_cmp++;
    if ({ramaddr, iwait, dwait} !== {RR ? 32'h204 : 32'h44, RR ? 1'b1 : 1'b0, RR ? 1'b0 : 1'b1}) begin
      n_bad++;
      $display("FAIL conflict_leftover: got addr=%h iwait=%b dwait=%b want addr=%h iwait=%b dwait=%b",
               ramaddr, iwait, dwait, RR ? 32'h204 : 32'h44, RR, !RR);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    dREN = 1'b1; daddr = 32'h300; ramstate = BUSY;
    tick(); #1;
    n_cmp++;
    if ({ramREN, dwait} !== 2'b11) begin
      n_bad++;
      $display("FAIL rstmid_active: got ren/dwait=%b want 11", {ramREN, dwait});
    end
    #2 nRST = 1'b0;
    #1;
    n_cmp++;
    if ({ramREN, ramWEN, ramaddr, ramstore, dwait, dload} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL rstmid_async: got ren=%b wen=%b addr=%h store=%h dwait=%b dload=%h want 0 0 0 0 1 0",
               ramREN, ramWEN, ramaddr, ramstore, dwait, dload);
    end
    tick();
    nRST = 1'b1; dREN = 1'b0; ramstate = ACCESS; ramload = 32'hBAD0_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_cmp++;
      if ({ramREN, dwait, dload} !== {1'b0, 1'b1, 32'h0}) begin
        n_bad++;
        $display("FAIL rstmid_after%0d: got ren=%b dwait=%b dload=%h want 0 1 0", c, ramREN, dwait, dload);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_drop();
    reset_dut();
    dREN = 1'b1; daddr = 32'h500; ramstate = BUSY;
    tick(); #1;
    n_cmp++;
    if ({ramREN, ramaddr, dwait} !== {1'b1, 32'h500, 1'b1}) begin
      n_bad++;
      $display("FAIL drop_active: got ren=%b addr=%h dwait=%b want 1 00000500 1", ramREN, ramaddr, dwait);
    end
    tick();
    dREN = 1'b0; ramstate = ACCESS;
    #1;
    n_cmp++;
    if (dwait !== 1'b1) begin
      n_bad++;
      $display("FAIL drop_cycle: got dwait=%b want 1", dwait);
    end
    tick(); #1;
    n_cmp++;
    if ({ramREN, dwait} !== 2'b01) begin
      n_bad++;
      $display("FAIL drop_idle: got ren/dwait=%b want 01", {ramREN, dwait});
    end
    idle_inputs();
  endtask

  task automatic test_error();
    reset_dut();
    iREN = 1'b1; iaddr = 32'h80; ramstate = ERROR; ramload = 32'hCAFE_0000;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) ramstate = ACCESS;
      if (c == 7) begin iREN = 1'b0; ramstate = FREE; end
      #1;
      n_cmp++;
      if (iwait !== (c != 6)) begin
        n_bad++;
        $display("FAIL error_cycle%0d: got iwait=%b want %b", c, iwait, (c != 6));
      end
      tick();
    end
  endtask

  task automatic test_random();
    int    owner, nxt, k;
    bit    last_d, i_done, d_done;
    logic  e_ren, e_wen, e_iw, e_dw;
    word_t e_addr, e_store, e_il, e_dl;
    reset_dut();
    owner = 0; last_d = 1'b0; i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (i_done || (iREN && $urandom_range(0, 15) == 0)) begin
        iREN = 1'b0;
      end else if (!iREN && $urandom_range(0, 2) == 0) begin
        iREN = 1'b1; iaddr = $urandom;
      end
      if (d_done || ((dREN || dWEN) && $urandom_range(0, 15) == 0)) begin
        dREN = 1'b0; dWEN = 1'b0;
      end else if (!(dREN || dWEN) && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        dREN = (k != 1); dWEN = (k != 0);
        daddr = $urandom; dstore = $urandom;
      end
      ramstate = ramstate_t'(2'($urandom_range(0, 3)));
      ramload  = $urandom;
      #1;
      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      e_iw = 1'b1; e_dw = 1'b1; e_il = '0; e_dl = '0;
      nxt = owner;
      if (owner == 0) begin
        if ((dREN || dWEN) && !(RR && iREN && last_d)) nxt = dWEN ? 3 : 2;
        else if (iREN) nxt = 1;
        if (nxt != 0) last_d = (nxt != 1);
      end else if (owner == 1) begin
        e_ren = 1'b1; e_addr = iaddr;
        if (!iREN) nxt = 0;
        else if (ramstate == ACCESS) begin e_iw = 1'b0; e_il = ramload; nxt = 0; end
      end else if (owner == 2) begin
        e_ren = 1'b1; e_addr = daddr;
        if (!dREN) nxt = 0;
        else if (ramstate == ACCESS) begin e_dw = 1'b0; e_dl = ramload; nxt = 0; end
      end else begin
        e_wen = 1'b1; e_addr = daddr; e_store = dstore;
        if (!dWEN) nxt = 0;
        else if (ramstate == ACCESS) begin e_dw = 1'b0; nxt = 0; end
      end
      n_cmp++;
      if ({ramREN, ramWEN, ramaddr, ramstore} !== {e_ren, e_wen, e_addr, e_store}) begin
        n_bad++;
        $display("FAIL rand_ram c%0d: got ren=%b wen=%b addr=%h store=%h want ren=%b wen=%b addr=%h store=%h",
                 c, ramREN, ramWEN, ramaddr, ramstore, e_ren, e_wen, e_addr, e_store);
      end
      n_cmp++;
      if ({iwait, iload} !== {e_iw, e_il}) begin
        n_bad++;
        $display("FAIL rand_icache c%0d: got iwait=%b iload=%h want iwait=%b iload=%h", c, iwait, iload, e_iw, e_il);
      end
      n_cmp++;
      if ({dwait, dload} !== {e_dw, e_dl}) begin
        n_bad++;
        $display("FAIL rand_dcache c%0d: got dwait=%b dload=%h want dwait=%b dload=%h", c, dwait, dload, e_dw, e_dl);
      end
      i_done = !e_iw;
      d_done = !e_dw;
      owner  = nxt;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ifetch_busy();
    test_dwrite();
    test_conflict();
    test_reset_mid();
    test_drop();
    test_error();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
